// File: rtl/pill_fill_ctrl_if.sv
// Bundles the tick/control inputs and the counter/status outputs of the pill
// filling controller. The controller uses the slave side; the environment drives the master side.
interface pill_fill_ctrl_if #(
  parameter int PILL_W   = 5,
  parameter int BOTTLE_W = 10,
  parameter int TOTAL_W  = 10
);
  logic                tick;
  logic                power;
  logic                pause;
  logic [PILL_W-1:0]   per_bottle;
  logic [BOTTLE_W-1:0] bottle_target;
  logic [PILL_W-1:0]   pill_count;
  logic [BOTTLE_W-1:0] bottle_count;
  logic [TOTAL_W-1:0]  total_pills;
  logic                dispense;
  logic [2:0]          state_o;
  logic                check;
  logic                change;
  logic                err;
  logic                done;

  modport master (
    output tick, power, pause, per_bottle, bottle_target,
    input  pill_count, bottle_count, total_pills, dispense,
           state_o, check, change, err, done
  );

  modport slave (
    input  tick, power, pause, per_bottle, bottle_target,
    output pill_count, bottle_count, total_pills, dispense,
           state_o, check, change, err, done
  );
endinterface

// File: rtl/pill_fill_ctrl.sv
// Multi-bottle pill filling sequencer. A tick enable from the divider advances the FSM.
// The controller fills each bottle to a latched limit and stops once the batch target is reached.
module pill_fill_ctrl #(
  parameter int PILL_W    = 5,
  parameter int MAX_PILLS = 20,
  parameter int BOTTLE_W  = 10,
  parameter int TOTAL_W   = 10
) (
  input logic            clock,
  input logic            rst,
  pill_fill_ctrl_if.slave bus
);

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_FILL   = 3'd2;
  localparam logic [2:0] ST_CHANGE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  localparam logic [PILL_W-1:0] MAX_L = PILL_W'(MAX_PILLS);

  logic [2:0]          state_q,        state_d;
  logic [PILL_W-1:0]   limit_q,        limit_d;
  logic [BOTTLE_W-1:0] target_q,       target_d;
  logic [PILL_W-1:0]   pill_count_q,   pill_count_d;
  logic [BOTTLE_W-1:0] bottle_count_q, bottle_count_d;
  logic [TOTAL_W-1:0]  total_q,        total_d;
  logic                dispense_q,     dispense_d;
  logic                err_q,          err_d;
  logic                done_q,         done_d;

  logic [BOTTLE_W-1:0] bottle_next;
  logic                limit_bad;

  assign bottle_next = bottle_count_q + BOTTLE_W'(1);
  assign limit_bad   = (bus.per_bottle == '0) || (bus.per_bottle > MAX_L);

  always_comb begin
    state_d        = state_q;
    limit_d        = limit_q;
    target_d       = target_q;
    pill_count_d   = pill_count_q;
    bottle_count_d = bottle_count_q;
    total_d        = total_q;
    dispense_d     = 1'b0;
    err_d          = err_q;
    done_d         = done_q;

    // power loss overrides everything, tick or not
    if (!bus.power) begin
      state_d        = ST_OFF;
      pill_count_d   = '0;
      bottle_count_d = '0;
      total_d        = '0;
      err_d          = 1'b0;
      done_d         = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (bus.tick) state_d = ST_CHECK;
        end
        ST_CHECK, ST_ERR: begin
          if (bus.tick) begin
            limit_d  = bus.per_bottle;
            target_d = bus.bottle_target;
            if (limit_bad) begin
              state_d = ST_ERR;
              err_d   = 1'b1;
            end else begin
              state_d      = ST_FILL;
              pill_count_d = '0;
              err_d        = 1'b0;
            end
          end
        end
        ST_FILL: begin
          if (bus.tick && !bus.pause) begin
            if (pill_count_q == limit_q) begin
              state_d = ST_CHANGE;
            end else begin
              pill_count_d = pill_count_q + PILL_W'(1);
              total_d      = total_q + TOTAL_W'(1);
              dispense_d   = 1'b1;
            end
          end
        end
        ST_CHANGE: begin
          if (bus.tick && !bus.pause) begin
            bottle_count_d = bottle_next;
            pill_count_d   = '0;
            // a zero target means run forever and let the bottle counter wrap
            if ((target_q != '0) && (bottle_next == target_q)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_OFF;
      limit_q        <= '0;
      target_q       <= '0;
      pill_count_q   <= '0;
      bottle_count_q <= '0;
      total_q        <= '0;
      dispense_q     <= 1'b0;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      limit_q        <= limit_d;
      target_q       <= target_d;
      pill_count_q   <= pill_count_d;
      bottle_count_q <= bottle_count_d;
      total_q        <= total_d;
      dispense_q     <= dispense_d;
      err_q          <= err_d;
      done_q         <= done_d;
    end
  end

  assign bus.pill_count   = pill_count_q;
  assign bus.bottle_count = bottle_count_q;
  assign bus.total_pills  = total_q;
  assign bus.dispense     = dispense_q;
  assign bus.err          = err_q;
  assign bus.done         = done_q;
  assign bus.state_o      = state_q;
  assign bus.check        = (state_q == ST_CHECK);
  assign bus.change       = (state_q == ST_CHANGE);

endmodule

// File: tb/tb_pill_fill_ctrl.sv
// Directed bench for pill_fill_ctrl: a default-width instance for the batch, error, pause, power and reset sequences,
// plus a narrow-counter instance for the wrap sequence.
module tb_pill_fill_ctrl;

  logic clock;
  logic rst;
  int   errors;
  int   checks;

  pill_fill_ctrl_if #(.PILL_W(5), .BOTTLE_W(10), .TOTAL_W(10)) bus_a ();
  pill_fill_ctrl_if #(.PILL_W(5), .BOTTLE_W(2),  .TOTAL_W(3))  bus_b ();

  pill_fill_ctrl #(.PILL_W(5), .MAX_PILLS(20), .BOTTLE_W(10), .TOTAL_W(10)) u_dut_a (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_a.slave)
  );

  pill_fill_ctrl #(.PILL_W(5), .MAX_PILLS(20), .BOTTLE_W(2), .TOTAL_W(3)) u_dut_b (
    .clock (clock),
    .rst   (rst),
    .bus   (bus_b.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // three idle clocks then a one-clock tick; returns 1 time unit after the tick edge
  task automatic applyStimulus(input bit sel_b);
    repeat (3) @(posedge clock);
    #1;
    if (sel_b) bus_b.tick = 1'b1;
    else       bus_a.tick = 1'b1;
    @(posedge clock);
    #1;
    bus_a.tick = 1'b0;
    bus_b.tick = 1'b0;
  endtask

  task automatic stepClock();
    @(posedge clock);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    bus_a.tick = 1'b0; bus_a.power = 1'b0; bus_a.pause = 1'b0;
    bus_a.per_bottle = '0; bus_a.bottle_target = '0;
    bus_b.tick = 1'b0; bus_b.power = 1'b0; bus_b.pause = 1'b0;
    bus_b.per_bottle = '0; bus_b.bottle_target = '0;

    repeat (2) @(posedge clock);
    #1;
    rst = 1'b1;
    stepClock();
    checkOutput("rst_state",  bus_a.state_o, 0);
    checkOutput("rst_pill",   bus_a.pill_count, 0);
    checkOutput("rst_bottle", bus_a.bottle_count, 0);
    checkOutput("rst_total",  bus_a.total_pills, 0);
    checkOutput("rst_flags",  {bus_a.dispense, bus_a.check, bus_a.change, bus_a.err, bus_a.done}, 0);

    // normal batch: 3 pills per bottle, 2 bottles
    bus_a.power = 1'b1;
    bus_a.per_bottle = 5'd3;
    bus_a.bottle_target = 10'd2;
    applyStimulus(0);
    checkOutput("off_to_check", bus_a.state_o, 1);
    checkOutput("check_flag", bus_a.check, 1);
    applyStimulus(0);
    checkOutput("t1_fill", bus_a.state_o, 2);
    checkOutput("t1_pill", bus_a.pill_count, 0);
    bus_a.per_bottle = 5'd1;
    bus_a.bottle_target = 10'd7;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0);
      checkOutput("fill_pill", bus_a.pill_count, i);
      checkOutput("fill_disp", bus_a.dispense, 1);
    end
    stepClock();
    checkOutput("disp_pulse_end", bus_a.dispense, 0);
    applyStimulus(0);
    checkOutput("t5_change", bus_a.state_o, 3);
    checkOutput("t5_change_flag", bus_a.change, 1);
    checkOutput("t5_no_disp", bus_a.dispense, 0);
    checkOutput("t5_pill_hold", bus_a.pill_count, 3);
    applyStimulus(0);
    checkOutput("t6_bottle", bus_a.bottle_count, 1);
    checkOutput("t6_pill", bus_a.pill_count, 0);
    checkOutput("t6_fill", bus_a.state_o, 2);
    repeat (3) applyStimulus(0);
    checkOutput("t9_pill", bus_a.pill_count, 3);
    applyStimulus(0);
    checkOutput("t10_change", bus_a.state_o, 3);
    applyStimulus(0);
    checkOutput("t11_bottle", bus_a.bottle_count, 2);
    checkOutput("t11_done", bus_a.done, 1);
    checkOutput("t11_state", bus_a.state_o, 4);
    checkOutput("t11_total", bus_a.total_pills, 6);
    applyStimulus(0);
    checkOutput("done_hold_state", bus_a.state_o, 4);
    checkOutput("done_hold_bottle", bus_a.bottle_count, 2);

    // power drop out of DONE clears everything on the next clock
    bus_a.power = 1'b0;
    stepClock();
    checkOutput("pwr_off_state", bus_a.state_o, 0);
    checkOutput("pwr_off_done", bus_a.done, 0);
    checkOutput("pwr_off_total", bus_a.total_pills, 0);

    // error path
    bus_a.power = 1'b1;
    bus_a.per_bottle = 5'd0;
    bus_a.bottle_target = 10'd0;
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("err_zero_state", bus_a.state_o, 5);
    checkOutput("err_zero_flag", bus_a.err, 1);
    bus_a.per_bottle = 5'd21;
    applyStimulus(0);
    checkOutput("err_21_state", bus_a.state_o, 5);
    checkOutput("err_21_flag", bus_a.err, 1);
    bus_a.per_bottle = 5'd20;
    applyStimulus(0);
    checkOutput("err_20_state", bus_a.state_o, 2);
    checkOutput("err_20_flag", bus_a.err, 0);
    repeat (20) applyStimulus(0);
    checkOutput("max_pill", bus_a.pill_count, 20);
    checkOutput("max_total", bus_a.total_pills, 20);
    applyStimulus(0);
    checkOutput("max_change", bus_a.state_o, 3);
    applyStimulus(0);
    checkOutput("max_bottle", bus_a.bottle_count, 1);
    checkOutput("unlimited_fill", bus_a.state_o, 2);

    // pause at pill_count=2
    repeat (2) applyStimulus(0);
    checkOutput("pre_pause_pill", bus_a.pill_count, 2);
    bus_a.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0);
      checkOutput("pause_pill", bus_a.pill_count, 2);
      checkOutput("pause_disp", bus_a.dispense, 0);
    end
    checkOutput("pause_total", bus_a.total_pills, 22);
    bus_a.pause = 1'b0;
    applyStimulus(0);
    checkOutput("resume_pill", bus_a.pill_count, 3);
    checkOutput("resume_disp", bus_a.dispense, 1);
    checkOutput("resume_total", bus_a.total_pills, 23);

    // power drop mid-FILL at pill 4 of bottle 3
    bus_a.power = 1'b0;
    stepClock();
    bus_a.power = 1'b1;
    bus_a.per_bottle = 5'd4;
    applyStimulus(0);
    applyStimulus(0);
    repeat (22) applyStimulus(0);
    checkOutput("mid_pill", bus_a.pill_count, 4);
    checkOutput("mid_bottle", bus_a.bottle_count, 3);
    checkOutput("mid_total", bus_a.total_pills, 16);
    bus_a.power = 1'b0;
    stepClock();
    checkOutput("drop_state", bus_a.state_o, 0);
    checkOutput("drop_counts", {bus_a.pill_count, bus_a.bottle_count, bus_a.total_pills}, 0);
    bus_a.power = 1'b1;
    applyStimulus(0);
    checkOutput("repower_check", bus_a.state_o, 1);

    // asynchronous reset mid-FILL at pill_count=2
    applyStimulus(0);
    repeat (2) applyStimulus(0);
    checkOutput("pre_rst_pill", bus_a.pill_count, 2);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_state", bus_a.state_o, 0);
    checkOutput("async_rst_pill", bus_a.pill_count, 0);
    checkOutput("async_rst_total", bus_a.total_pills, 0);
    @(posedge clock);
    #1;
    rst = 1'b1;
    bus_a.power = 1'b0;

    // wrap on the narrow instance: 1 pill per bottle, unlimited target
    bus_b.power = 1'b1;
    bus_b.per_bottle = 5'd1;
    bus_b.bottle_target = 2'd0;
    applyStimulus(1);
    applyStimulus(1);
    checkOutput("wrap_fill", bus_b.state_o, 2);
    for (int k = 1; k <= 8; k++) begin
      repeat (3) applyStimulus(1);
      checkOutput("wrap_bottle", bus_b.bottle_count, k % 4);
      checkOutput("wrap_total", bus_b.total_pills, k % 8);
      checkOutput("wrap_no_done", bus_b.done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
